// File: rtl/instruction_encoder.sv
// instruction_encoder
// Builds RV32I instruction words from discrete fields and an immediate, then
// streams them to an instruction-memory write port at consecutive word
// addresses. One load session runs from a start pulse until the last beat has
// been written or the session fills up.
module instruction_encoder #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_fmt,
  input  logic [6:0]        in_opcode,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              done,
  output logic              err
);

  // Session capacity in the width of the word counter.
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  // Instruction formats as carried on in_fmt; 6 and 7 are not formats.
  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // Per-format packers. Immediate bits outside each format's field are simply
  // dropped; no range check is done on the immediate.
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] pack_r(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd, input logic [6:0] op);
    return {f7, rs2, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] pack_i(input logic [31:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd,
                                         input logic [6:0] op);
    return {imm[11:0], rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] pack_s(input logic [31:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [6:0] op);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], op};
  endfunction

  // Branch immediate is a byte offset; bit 0 is implicitly zero and not stored.
  function automatic logic [31:0] pack_b(input logic [31:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [6:0] op);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
  endfunction

  function automatic logic [31:0] pack_u(input logic [31:0] imm, input logic [4:0] rd,
                                         input logic [6:0] op);
    return {imm[31:12], rd, op};
  endfunction

  // Jump immediate is a byte offset; bit 0 is implicitly zero and not stored.
  function automatic logic [31:0] pack_j(input logic [31:0] imm, input logic [4:0] rd,
                                         input logic [6:0] op);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e            state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W:0]   count_q;
  logic              last_q;      // accepted in_last beat is in its write cycle
  logic              in_ready_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic              done_q;
  logic              err_q;

  // Combinational helpers for the accepting edge
  logic              accept;
  logic              fmt_legal;
  logic [31:0]       word_d;
  logic [ADDR_W:0]   count_d;
  logic              full_d;

  assign accept    = in_valid && in_ready_q;
  assign fmt_legal = (in_fmt <= 3'd5);

  // Select the packed word for the presented format.
  always_comb begin
    word_d = 32'h0;
    case (in_fmt)
      FMT_R:   word_d = pack_r(in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode);
      FMT_I:   word_d = pack_i(in_imm, in_rs1, in_funct3, in_rd, in_opcode);
      FMT_S:   word_d = pack_s(in_imm, in_rs2, in_rs1, in_funct3, in_opcode);
      FMT_B:   word_d = pack_b(in_imm, in_rs2, in_rs1, in_funct3, in_opcode);
      FMT_U:   word_d = pack_u(in_imm, in_rd, in_opcode);
      FMT_J:   word_d = pack_j(in_imm, in_rd, in_opcode);
      default: word_d = 32'h0;
    endcase
  end

  // Word count after the current beat: illegal formats do not consume a slot.
  always_comb begin
    count_d = count_q;
    if (accept && fmt_legal) begin
      count_d = count_q + 1'b1;
    end
    full_d = (count_d >= DEPTH_C);
  end

  // Session FSM; every output is a register so the memory port sees clean edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      count_q     <= '0;
      last_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      // Writes are single-cycle pulses unless re-armed below.
      mem_we_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q    <= ST_LOAD;
            ptr_q      <= '0;
            count_q    <= '0;
            last_q     <= 1'b0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
            in_ready_q <= (DEPTH_C != '0);
          end
        end

        ST_LOAD: begin
          if (last_q || (count_q >= DEPTH_C)) begin
            // The final write is on the port this cycle; close the session.
            // Filling up without a last beat is an overflow.
            state_q    <= ST_DONE;
            done_q     <= 1'b1;
            in_ready_q <= 1'b0;
            last_q     <= 1'b0;
            if (!last_q) begin
              err_q <= 1'b1;
            end
          end else if (accept) begin
            if (fmt_legal) begin
              mem_we_q    <= 1'b1;
              mem_addr_q  <= ptr_q;
              mem_wdata_q <= word_d;
              ptr_q       <= ptr_q + 1'b1;
            end else begin
              err_q <= 1'b1;
            end
            count_q    <= count_d;
            last_q     <= in_last;
            in_ready_q <= !in_last && !full_d;
          end
        end

        default: begin
          state_q    <= ST_IDLE;
          in_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign count     = count_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_instruction_encoder.sv
// Directed testbench for instruction_encoder. Stimulus pushes the expected
// {addr, word} of every legal beat into a queue; a negedge monitor pops and
// compares on each mem_we.
module tb_instruction_encoder;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 256;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_fmt;
  logic [6:0]        in_opcode;
  logic [2:0]        in_funct3;
  logic [6:0]        in_funct7;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [31:0]       in_imm;
  logic              in_last;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [ADDR_W:0]   count;
  logic              done;
  logic              err;

  instruction_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_funct3(in_funct3),
    .in_funct7(in_funct7), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm(in_imm), .in_last(in_last),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .count(count), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [ADDR_W+31:0] exp_q[$];
  logic [ADDR_W-1:0]  exp_ptr;
  int cur_run = 0;
  int max_run = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end else begin
      $display("ok   %s = 0x%0h", name, act);
    end
  endtask

  // Monitor: every write must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (mem_we) begin
      cur_run++;
      if (cur_run > max_run) max_run = cur_run;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write actual addr=0x%0h data=0x%08h required=no write",
                 mem_addr, mem_wdata);
      end else begin
        logic [ADDR_W+31:0] e;
        e = exp_q.pop_front();
        if ({mem_addr, mem_wdata} !== e) begin
          errors++;
          $display("FAIL write actual addr=0x%0h data=0x%08h required addr=0x%0h data=0x%08h",
                   mem_addr, mem_wdata, e[ADDR_W+31:32], e[31:0]);
        end else begin
          $display("ok   write addr=0x%0h data=0x%08h", mem_addr, mem_wdata);
        end
      end
    end else begin
      cur_run = 0;
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    exp_ptr = '0;
  endtask

  // Present one beat at a negedge once in_ready is high; it transfers at the
  // following posedge. in_valid stays high so beats can run back to back.
  task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [31:0] imm, input logic last,
                      input logic [31:0] exp_word);
    int waited;
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 20) begin
      in_valid = 1'b0;
      waited++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout actual=0 required=1");
    end else begin
      in_fmt = fmt; in_opcode = op; in_funct3 = f3; in_funct7 = f7;
      in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_last = last;
      in_valid = 1'b1;
      if (fmt <= 3'd5) begin
        exp_q.push_back({exp_ptr, exp_word});
        exp_ptr = exp_ptr + 1'b1;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_fmt = '0; in_opcode = '0;
    in_funct3 = '0; in_funct7 = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_imm = '0; in_last = 1'b0; exp_ptr = '0;
    repeat (2) @(negedge clk);
    check("reset_in_ready", 64'(in_ready), 64'd0);
    check("reset_outputs", {mem_we, done, err, count, mem_addr, mem_wdata}, 64'd0);
    rst_n = 1'b1;

    // 1: single R beat with last
    pulse_start();
    send(3'd0, 7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 32'h002081B3);
    idle(3);
    check("t1_count", 64'(count), 64'd1);
    check("t1_done", 64'(done), 64'd1);
    check("t1_err", 64'(err), 64'd0);
    check("t1_in_ready", 64'(in_ready), 64'd0);

    // 2: I then S
    pulse_start();
    check("t2_cleared", {done, err, count}, 64'd0);
    send(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFF, 1'b0, 32'hFFF00093);
    send(3'd2, 7'h23, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b1, 32'h0020A423);
    idle(3);
    check("t2_count", 64'(count), 64'd2);
    check("t2_done", 64'(done), 64'd1);

    // 3: J then B with negative offset
    pulse_start();
    send(3'd5, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd8, 1'b0, 32'h008000EF);
    send(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFC, 1'b1, 32'hFE000EE3);
    idle(3);
    check("t3_count", 64'(count), 64'd2);

    // 4: four back-to-back beats, no bubbles
    pulse_start();
    max_run = 0;
    send(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd1, 1'b0, 32'h00100093);
    send(3'd1, 7'h13, 3'd0, 7'd0, 5'd2, 5'd0, 5'd0, 32'd2, 1'b0, 32'h00200113);
    send(3'd1, 7'h13, 3'd0, 7'd0, 5'd3, 5'd0, 5'd0, 32'd3, 1'b0, 32'h00300193);
    send(3'd1, 7'h13, 3'd0, 7'd0, 5'd4, 5'd0, 5'd0, 32'd4, 1'b1, 32'h00400213);
    idle(3);
    check("t4_run_length", 64'(max_run), 64'd4);
    check("t4_count", 64'(count), 64'd4);

    // 5: illegal format in the middle
    pulse_start();
    send(3'd0, 7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0, 32'h002081B3);
    send(3'd7, 7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0, 32'h0);
    send(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFF, 1'b1, 32'hFFF00093);
    idle(3);
    check("t5_err", 64'(err), 64'd1);
    check("t5_count", 64'(count), 64'd2);
    check("t5_done", 64'(done), 64'd1);

    // 6: overflow, DEPTH words then the extra beat is refused
    pulse_start();
    for (int i = 0; i < DEPTH; i++) begin
      send(3'd4, 7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'(i) << 12, 1'b0,
           (32'(i) << 12) | 32'h000002B7);
    end
    @(negedge clk);
    in_fmt = 3'd4; in_imm = 32'hABCDE000; in_last = 1'b0; in_valid = 1'b1;
    check("t6_ready_full", 64'(in_ready), 64'd0);
    @(negedge clk);
    check("t6_ready_done", 64'(in_ready), 64'd0);
    check("t6_done", 64'(done), 64'd1);
    @(negedge clk);
    check("t6_err", 64'(err), 64'd1);
    check("t6_count", 64'(count), 64'(DEPTH));
    idle(2);

    // Reset mid-stream: second beat's write is dropped
    pulse_start();
    send(3'd0, 7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0, 32'h002081B3);
    @(negedge clk);
    in_rd = 5'd4;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("rst_outputs", {mem_we, done, err, count, mem_addr, mem_wdata}, 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    rst_n = 1'b1;
    idle(3);
    check("no_write_after_reset", {mem_we, count}, 64'd0);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
